// File: rtl/split_channels_if.sv
// split_channels_if -- stream bus of the split_channels block.
//   Input side : data_valid_i, data_i (signed sample), sop_i/eop_i (pixel
//                markers), sof_i/eof_i (frame markers).
//   Output side: data_valid_o, data_o[NUMBER_SPLIT_CHANNELS] (one sample per
//                lane), sop_o/eop_o/sof_o/eof_o, err_o (framing-error pulse).
//   slave  : seen by split_channels (consumes *_i, drives *_o).
//   master : seen by the upstream/downstream environment.
interface split_channels_if #(
  parameter int DATA_WIDTH            = 8,
  parameter int NUMBER_SPLIT_CHANNELS = 2
);
  logic                                               data_valid_i;
  logic signed [DATA_WIDTH-1:0]                       data_i;
  logic                                               sop_i, eop_i, sof_i, eof_i;
  logic [NUMBER_SPLIT_CHANNELS-1:0][DATA_WIDTH-1:0]   data_o;
  logic                                               data_valid_o;
  logic                                               sop_o, eop_o, sof_o, eof_o;
  logic                                               err_o;

  modport slave (
    input  data_valid_i, data_i, sop_i, eop_i, sof_i, eof_i,
    output data_o, data_valid_o, sop_o, eop_o, sof_o, eof_o, err_o
  );

  modport master (
    output data_valid_i, data_i, sop_i, eop_i, sof_i, eof_i,
    input  data_o, data_valid_o, sop_o, eop_o, sof_o, eof_o, err_o
  );
endinterface

// File: rtl/split_channels.sv
// split_channels -- serial-to-parallel lane splitter.
//   A pixel arrives as N groups of C valid beats. Groups 0..N-2 are parked in
//   per-lane buffers (FILL); each beat of group N-1 (DRAIN) emits, one clk
//   later, a parallel beat carrying buffer[g][k] on lanes 0..N-2 and the live
//   sample on lane N-1. No backpressure; output gaps follow input gaps.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : split_channels_if.slave (input stream, parallel output, err_o)

// One output lane: optional C-deep sample buffer plus the output register.
module split_channels_lane #(
  parameter int DW       = 8,
  parameter int C        = 8,
  parameter bit BUFFERED = 1'b1,
  parameter int BW       = $clog2(C)
) (
  input  logic                 clk,
  input  logic                 wr_en_i,
  input  logic                 ld_en_i,
  input  logic [BW-1:0]        idx_i,
  input  logic signed [DW-1:0] din_i,
  output logic [DW-1:0]        dout_o
);
  generate
    if (BUFFERED) begin : g_buf
      logic [DW-1:0] mem_q [C];
      always_ff @(posedge clk) begin
        if (wr_en_i) mem_q[idx_i] <= din_i;
      end
      // Read and write use the same index but never the same cycle for one
      // lane, so the next pixel may refill right after the last drain beat.
      always_ff @(posedge clk) begin
        if (ld_en_i) dout_o <= mem_q[idx_i];
      end
    end else begin : g_pass
      logic unused_in;
      assign unused_in = ^{wr_en_i, idx_i};
      always_ff @(posedge clk) begin
        if (ld_en_i) dout_o <= din_i;
      end
    end
  endgenerate
endmodule

module split_channels #(
  parameter int DATA_WIDTH            = 8,
  parameter int NUMBER_SPLIT_CHANNELS = 2,
  parameter int CHANNEL_NUM           = 8
) (
  input  logic             clk,
  input  logic             reset,
  split_channels_if.slave  bus
);
  localparam int N  = NUMBER_SPLIT_CHANNELS;
  localparam int C  = CHANNEL_NUM;
  localparam int BW = $clog2(C);
  localparam int GW = $clog2(N);
  localparam logic [BW-1:0] LAST_BEAT = BW'(C-1);
  localparam logic [GW-1:0] LAST_GRP  = GW'(N-1);

  typedef enum logic {FILL, DRAIN} state_e;

  logic [BW-1:0] beat_cnt_q, beat_cnt_d, pos_beat;
  logic [GW-1:0] grp_cnt_q,  grp_cnt_d,  pos_grp;
  logic          sof_pend_q, sof_pend_d;
  state_e        state;
  logic          vld, sop_err, eop_err, beat_ok, fill_wr, drain;
  logic          sop_d, eop_d, sof_d, eof_d, err_d;

  logic          data_valid_q, sop_q, eop_q, sof_q, eof_q, err_q;
  logic [N-1:0][DATA_WIDTH-1:0] lane_q;

  always_comb begin
    vld      = bus.data_valid_i;
    // A valid sop_i always re-anchors the pixel at group 0, beat 0; the eop
    // check below is then made against this restarted position.
    pos_beat = (vld && bus.sop_i) ? '0 : beat_cnt_q;
    pos_grp  = (vld && bus.sop_i) ? '0 : grp_cnt_q;
    sop_err  = vld && bus.sop_i && ((grp_cnt_q != '0) || (beat_cnt_q != '0));
    eop_err  = vld && bus.eop_i && !((pos_grp == LAST_GRP) && (pos_beat == LAST_BEAT));
    state    = (pos_grp == LAST_GRP) ? DRAIN : FILL;

    beat_ok  = vld && !eop_err;
    fill_wr  = beat_ok && (state == FILL);
    drain    = beat_ok && (state == DRAIN);

    beat_cnt_d = beat_cnt_q;
    grp_cnt_d  = grp_cnt_q;
    if (vld) begin
      if (eop_err) begin
        beat_cnt_d = '0;
        grp_cnt_d  = '0;
      end else if (pos_beat == LAST_BEAT) begin
        beat_cnt_d = '0;
        grp_cnt_d  = (pos_grp == LAST_GRP) ? '0 : pos_grp + GW'(1);
      end else begin
        beat_cnt_d = pos_beat + BW'(1);
        grp_cnt_d  = pos_grp;
      end
    end

    sop_d = drain && (pos_beat == '0);
    eop_d = drain && (pos_beat == LAST_BEAT);
    // sof_i may ride on the very beat that produces sop_o; honour it directly.
    sof_d = sop_d && (sof_pend_q || (vld && bus.sof_i));
    eof_d = eop_d && bus.eof_i;
    err_d = sop_err || eop_err;

    sof_pend_d = sof_d ? 1'b0 : (sof_pend_q || (vld && bus.sof_i));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      beat_cnt_q   <= '0;
      grp_cnt_q    <= '0;
      sof_pend_q   <= 1'b0;
      data_valid_q <= 1'b0;
      sop_q        <= 1'b0;
      eop_q        <= 1'b0;
      sof_q        <= 1'b0;
      eof_q        <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      beat_cnt_q   <= beat_cnt_d;
      grp_cnt_q    <= grp_cnt_d;
      sof_pend_q   <= sof_pend_d;
      data_valid_q <= drain;
      sop_q        <= sop_d;
      eop_q        <= eop_d;
      sof_q        <= sof_d;
      eof_q        <= eof_d;
      err_q        <= err_d;
    end
  end

  // Lane buffers are not reset: after reset the counters restart at group 0,
  // so every entry is rewritten before any drain beat can read it.
  generate
    for (genvar g = 0; g < N; g++) begin : g_lane
      split_channels_lane #(
        .DW       (DATA_WIDTH),
        .C        (C),
        .BUFFERED (g < N-1)
      ) u_lane (
        .clk     (clk),
        .wr_en_i (fill_wr && !reset && (pos_grp == GW'(g))),
        .ld_en_i (drain),
        .idx_i   (pos_beat),
        .din_i   (bus.data_i),
        .dout_o  (lane_q[g])
      );
    end
  endgenerate

  assign bus.data_o       = lane_q;
  assign bus.data_valid_o = data_valid_q;
  assign bus.sop_o        = sop_q;
  assign bus.eop_o        = eop_q;
  assign bus.sof_o        = sof_q;
  assign bus.eof_o        = eof_q;
  assign bus.err_o        = err_q;
endmodule

// File: tb/tb_split_channels.sv
module tb_split_channels;
  localparam int DW = 8;
  localparam int N  = 2;
  localparam int C  = 8;

  logic clk = 1'b0;
  logic reset;

  split_channels_if #(.DATA_WIDTH(DW), .NUMBER_SPLIT_CHANNELS(N)) bus ();

  split_channels #(
    .DATA_WIDTH            (DW),
    .NUMBER_SPLIT_CHANNELS (N),
    .CHANNEL_NUM           (C)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic       rst, vld, sop, eop, sof, eof;
    logic [7:0] din;
    logic       ev;
    logic [7:0] ed0, ed1;
    logic       esop, eeop, esof, eeof, eerr;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  task automatic row(input string tag, input logic rst, vld, sop, eop, sof, eof,
                     input logic [7:0] din, input logic ev, input logic [7:0] ed0, ed1,
                     input logic esop, eeop, esof, eeof, eerr);
    vec_t v;
    v.tag = tag; v.rst = rst; v.vld = vld; v.sop = sop; v.eop = eop;
    v.sof = sof; v.eof = eof; v.din = din; v.ev = ev; v.ed0 = ed0; v.ed1 = ed1;
    v.esop = esop; v.eeop = eeop; v.esof = esof; v.eeof = eeof; v.eerr = eerr;
    tbl.push_back(v);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++)
      row(tag, 0, 0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0);
  endtask

  task automatic pixel(input string tag, input logic [7:0] base, input logic sof,
                       input logic eof, input bit gaps, input bit err0);
    for (int b = 0; b < 16; b++) begin
      logic [7:0] d;
      d = base + 8'(b);
      row(tag, 0, 1, b == 0, b == 15, sof && (b == 0), eof && (b == 15), d,
          b >= 8, base + 8'(b) - 8'd8, d,
          b == 8, b == 15, sof && (b == 8), eof && (b == 15), err0 && (b == 0));
      if (gaps) idle(tag, 1);
    end
  endtask

  initial begin
    int nout;
    int neop;
    int wait_cyc;

    reset = 1'b1;
    bus.data_valid_i = 1'b0; bus.data_i = '0;
    bus.sop_i = 1'b0; bus.eop_i = 1'b0; bus.sof_i = 1'b0; bus.eof_i = 1'b0;

    @(negedge clk);
    bus.data_valid_i = 1'b1; bus.data_i = 8'h5A; bus.sop_i = 1'b1; bus.sof_i = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    checks++;
    if (bus.data_valid_o !== 1'b0 || bus.sop_o !== 1'b0 || bus.eop_o !== 1'b0 ||
        bus.sof_o !== 1'b0 || bus.eof_o !== 1'b0 || bus.err_o !== 1'b0) begin
      errors++;
      $display("FAIL reset-state: vld=%b sop=%b eop=%b sof=%b eof=%b err=%b",
               bus.data_valid_o, bus.sop_o, bus.eop_o, bus.sof_o, bus.eof_o, bus.err_o);
    end

    row("reset", 1, 0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0);
    row("reset", 1, 1, 1, 0, 1, 0, 8'h55, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0);

    pixel("b2b0", 8'h00, 0, 0, 0, 0);
    pixel("b2b1", 8'h20, 0, 0, 0, 0);
    idle("idle", 2);

    pixel("gap", 8'h30, 0, 0, 1, 0);

    pixel("frm0", 8'h40, 1, 0, 0, 0);
    pixel("frm1", 8'h50, 0, 0, 0, 0);
    pixel("frm2", 8'h60, 0, 1, 0, 0);

    for (int b = 0; b < 5; b++)
      row("esop_pre", 0, 1, b == 0, 0, 0, 0, 8'h70 + 8'(b), 0, 8'h00, 8'h00, 0, 0, 0, 0, 0);
    pixel("esop", 8'h80, 0, 0, 0, 1);

    for (int b = 0; b < 11; b++)
      row("rst_pre", 0, 1, b == 0, 0, 0, 0, 8'h90 + 8'(b), b >= 8,
          8'h90 + 8'(b) - 8'd8, 8'h90 + 8'(b), b == 8, 0, 0, 0, 0);
    row("rst_mid", 1, 1, 0, 0, 0, 0, 8'hEE, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0);
    idle("rst_mid", 1);
    pixel("after_rst", 8'hA0, 0, 0, 0, 0);

    for (int b = 0; b < 11; b++)
      row("eeop_pre", 0, 1, b == 0, 0, 0, 0, 8'hB0 + 8'(b), b >= 8,
          8'hB0 + 8'(b) - 8'd8, 8'hB0 + 8'(b), b == 8, 0, 0, 0, 0);
    row("eeop", 0, 1, 0, 1, 0, 0, 8'hBB, 0, 8'h00, 8'h00, 0, 0, 0, 0, 1);
    pixel("after_eop", 8'hC0, 0, 0, 0, 0);

    for (int b = 0; b < 3; b++)
      row("se_pre", 0, 1, b == 0, 0, 0, 0, 8'hD0 + 8'(b), 0, 8'h00, 8'h00, 0, 0, 0, 0, 0);
    row("sop_eop", 0, 1, 1, 1, 0, 0, 8'hDD, 0, 8'h00, 8'h00, 0, 0, 0, 0, 1);
    pixel("after_se", 8'hE0, 0, 0, 0, 0);
    idle("tail", 2);

    foreach (tbl[i]) begin
      @(negedge clk);
      reset            = tbl[i].rst;
      bus.data_valid_i = tbl[i].vld;
      bus.data_i       = tbl[i].din;
      bus.sop_i        = tbl[i].sop;
      bus.eop_i        = tbl[i].eop;
      bus.sof_i        = tbl[i].sof;
      bus.eof_i        = tbl[i].eof;
      @(posedge clk);
      #1;
      checks++;
      if (bus.data_valid_o !== tbl[i].ev   || bus.sop_o !== tbl[i].esop ||
          bus.eop_o        !== tbl[i].eeop || bus.sof_o !== tbl[i].esof ||
          bus.eof_o        !== tbl[i].eeof || bus.err_o !== tbl[i].eerr ||
          (tbl[i].ev && (bus.data_o[0] !== tbl[i].ed0 || bus.data_o[1] !== tbl[i].ed1))) begin
        errors++;
        $display("FAIL %s row %0d: got vld=%b d0=%h d1=%h sop=%b eop=%b sof=%b eof=%b err=%b, want vld=%b d0=%h d1=%h sop=%b eop=%b sof=%b eof=%b err=%b",
                 tbl[i].tag, i, bus.data_valid_o, bus.data_o[0], bus.data_o[1],
                 bus.sop_o, bus.eop_o, bus.sof_o, bus.eof_o, bus.err_o,
                 tbl[i].ev, tbl[i].ed0, tbl[i].ed1, tbl[i].esop, tbl[i].eeop,
                 tbl[i].esof, tbl[i].eeof, tbl[i].eerr);
      end
    end

    nout = 0;
    neop = 0;
    for (int b = 0; b < 16; b++) begin
      @(negedge clk);
      reset            = 1'b0;
      bus.data_valid_i = 1'b1;
      bus.data_i       = 8'hF0 + 8'(b);
      bus.sop_i        = (b == 0);
      bus.eop_i        = (b == 15);
      bus.sof_i        = 1'b0;
      bus.eof_i        = 1'b0;
      @(posedge clk);
      #1;
      if (bus.data_valid_o === 1'b1) nout++;
      if (bus.eop_o === 1'b1) neop++;
    end
    @(negedge clk);
    bus.data_valid_i = 1'b0; bus.sop_i = 1'b0; bus.eop_i = 1'b0;
    wait_cyc = 0;
    while (neop == 0 && wait_cyc < 4) begin
      @(posedge clk);
      #1;
      if (bus.data_valid_o === 1'b1) nout++;
      if (bus.eop_o === 1'b1) neop++;
      wait_cyc++;
    end
    checks++;
    if (neop != 1 || nout != 8) begin
      errors++;
      $display("FAIL wait expired: %0d output beats, %0d eop_o after %0d extra cycles",
               nout, neop, wait_cyc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/split_channels.md
SPLIT_CHANNELS -- requirements
Module: split_channels

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: bits per channel sample.
REQ-002 SHALL have parameter NUMBER_SPLIT_CHANNELS, default 2: number of output lanes N; legal range 2 or more.
REQ-003 SHALL have parameter CHANNEL_NUM, default 8: samples per lane per pixel C; legal range 2 or more.
REQ-004 SHALL use one clock and a synchronous active-high reset; the decision is fixed.
REQ-005 SHALL have port clk, input, 1 bit: the only clock; all logic samples on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous active-high reset.
REQ-007 SHALL have port data_valid_i, input, 1 bit: input beat qualifier.
REQ-008 SHALL have port data_i, input, signed DATA_WIDTH bits: serialized sample.
REQ-009 SHALL have ports sop_i, eop_i, sof_i, eof_i, input, 1 bit each: pixel and frame markers, meaningful only when data_valid_i=1.
REQ-010 SHALL have port data_o[0:N-1], output, signed DATA_WIDTH bits per lane: parallel lane samples.
REQ-011 SHALL have ports data_valid_o, sop_o, eop_o, sof_o, eof_o, output, 1 bit each: output beat qualifier and markers.
REQ-012 SHALL have port err_o, output, 1 bit: one-cycle framing-error pulse.

Function
REQ-013 SHALL treat each input pixel as N*C valid beats, sent as groups g=0..N-1 of C beats each; idle gaps with data_valid_i=0 are allowed anywhere.
REQ-014 SHALL track the position with beat_cnt (0..C-1) and grp_cnt (0..N-1), both advancing only on valid beats.
REQ-015 SHALL wrap beat_cnt from C-1 to 0 and increment grp_cnt at that point; grp_cnt SHALL wrap from N-1 to 0.
REQ-016 SHALL be in state FILL when grp_cnt<N-1: each valid beat is written to buffer[grp_cnt][beat_cnt], an (N-1)xC register array, and no output is produced.
REQ-017 SHALL be in state DRAIN when grp_cnt=N-1: the valid beat k produces, one cycle later, data_valid_o=1, data_o[g]=buffer[g][k] for g<N-1, and data_o[N-1]=the input sample.
REQ-018 SHALL have a latency of exactly one clk from the DRAIN input beat to its output beat, with no backpressure; output gaps SHALL mirror input gaps.
REQ-019 SHALL assert sop_o on output beat k=0 and eop_o on output beat k=C-1.
REQ-020 SHALL latch sof_i seen on a valid beat into sof_pend, assert sof_o with the next sop_o, and clear sof_pend in that same cycle.
REQ-021 SHALL assert eof_o together with eop_o when eof_i was present on the corresponding input beat.
REQ-022 SHALL, on a valid sop_i while not at grp_cnt=0 and beat_cnt=0, pulse err_o, discard the partial pixel, and restart counting with this beat as group 0, beat 0.
REQ-023 SHALL, on a valid eop_i while not at grp_cnt=N-1 and beat_cnt=C-1, pulse err_o, suppress output for that beat, and return the counters to 0.
REQ-024 SHALL, when sop_i and eop_i arrive together on one beat, apply the sop_i handling of REQ-022 first and then the eop_i check of REQ-023 against the restarted position.
REQ-025 SHALL keep data_o values unspecified while data_valid_o=0, and all markers SHALL be 0 while data_valid_o=0.
REQ-026 SHALL allow the next pixel's group 0 to start writing the buffer on the cycle immediately after the last DRAIN beat, with no corruption of the output.

Reset
REQ-027 SHALL, while reset=1 at a clk edge, force beat_cnt=0, grp_cnt=0, sof_pend=0, data_valid_o=0, sop_o=0, eop_o=0, sof_o=0, eof_o=0, and err_o=0.
REQ-028 SHALL drop any partial pixel when reset occurs mid-pixel; buffer contents need no reset and SHALL never reach the output before being rewritten.
REQ-029 SHALL accept the first beat after reset as group 0, beat 0.

Verification (N=2, C=8, DATA_WIDTH=8)
REQ-030 SHALL cover back-to-back pixels: input 0..15 continuous, sop_i on 0, eop_i on 15 -> outputs start at the cycle after input 8; lane pairs (0,8),(1,9)...(7,15); sop_o on the first pair, eop_o on the last.
REQ-031 SHALL cover gapped input: the same pixel with data_valid_i toggling 1/0 -> identical pairs, each emitted one cycle after its group-1 beat, with matching gaps.
REQ-032 SHALL cover framing: 3 pixels, sof_i on beat 0 of pixel 0 and eof_i on beat 15 of pixel 2 -> sof_o only on pixel 0's sop_o, eof_o only on pixel 2's eop_o.
REQ-033 SHALL cover an early sop_i: sop_i at beat 5 of group 0 -> err_o pulses once; the following 16 beats produce one correct pixel.
REQ-034 SHALL cover reset mid-pixel: reset for 1 cycle after 11 beats -> no outputs from the partial pixel; the next full pixel is emitted correctly.
REQ-035 SHALL cover an early eop_i: eop_i on beat 3 of group 1 -> err_o pulses and no output on that beat; the next pixel is correct.
